// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master and slave ports: state encoding,
// default widths and the bit-index width helper.
package bus_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_RWAIT = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ADDR  = ST_ADDR,
        S_WDATA = ST_WDATA,
        S_RWAIT = ST_RWAIT,
        S_RDATA = ST_RDATA,
        S_DONE  = ST_DONE
    } state_e;

    // Width of a bit index that can address every bit of the wider field.
    function automatic int idx_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// LSB-first shift register with parallel load, serial shift-in and a bit
// counter whose terminal index is supplied per phase by the owner.
module serial_shifter #(
    parameter int W     = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [W-1:0]     load_data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] last_idx_i,
    output logic [W-1:0]     data_o,
    output logic             last_o
);

    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = '0;
        end else begin
            if (shift_i) begin
                data_d = {ser_i, data_q[W-1:1]};
            end
            // Clearing wins so the owner can shift the final bit and reset the index together.
            if (clr_i) begin
                cnt_d = '0;
            end else if (shift_i) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;
    assign last_o = (cnt_q == last_idx_i);

endmodule

// File: rtl/master_port.sv
// Initiator side of the single-bit serial bus: serializes address and write
// data, deserializes read data, and aborts reads that stall too long.
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    // Device side: a request transfers on a rising edge where dvalid and dready
    // are both high; dvalid while busy is dropped, never queued.
    input  logic                  dvalid,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  drvalid,
    output logic                  dwdone,
    output logic                  derr,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  mrdata,
    input  logic                  svalid,
    output state_e                dbg_state
);

    localparam int TX_W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int IDX_W = idx_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_WIDTH - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
    logic                  drvalid_q, drvalid_d;
    logic                  dwdone_q, dwdone_d;
    logic                  derr_q, derr_d;
    logic                  mvalid_q, mvalid_d;

    logic                  tx_load, tx_shift, tx_clr, tx_last;
    logic [IDX_W-1:0]      tx_last_idx;
    logic [TX_W-1:0]       tx_load_data, tx_data;
    logic                  rx_shift, rx_clr, rx_last;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  unused_bits;

    // Read requests load zeros in the data field so mwdata idles low after the address.
    assign tx_load_data = {(dmode ? dwdata : {DATA_WIDTH{1'b0}}), daddr};
    assign tx_last_idx  = (state_q == S_ADDR) ? ADDR_LAST : DATA_LAST;

    serial_shifter #(.W(TX_W), .CNT_W(IDX_W)) u_tx (
        .clk         (clk),
        .rst         (rst),
        .load_i      (tx_load),
        .load_data_i (tx_load_data),
        .shift_i     (tx_shift),
        .ser_i       (1'b0),
        .clr_i       (tx_clr),
        .last_idx_i  (tx_last_idx),
        .data_o      (tx_data),
        .last_o      (tx_last)
    );

    serial_shifter #(.W(DATA_WIDTH), .CNT_W(IDX_W)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .load_data_i ({DATA_WIDTH{1'b0}}),
        .shift_i     (rx_shift),
        .ser_i       (mrdata),
        .clr_i       (rx_clr),
        .last_idx_i  (DATA_LAST),
        .data_o      (rx_data),
        .last_o      (rx_last)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        to_d      = '0;
        drdata_d  = drdata_q;
        drvalid_d = 1'b0;
        dwdone_d  = 1'b0;
        derr_d    = 1'b0;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
        tx_clr    = 1'b0;
        rx_shift  = 1'b0;
        rx_clr    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mode_d = 1'b0;
                if (dvalid) begin
                    tx_load = 1'b1;
                    mode_d  = dmode;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                tx_shift = 1'b1;
                if (tx_last) begin
                    tx_clr  = 1'b1;
                    state_d = mode_q ? S_WDATA : S_RWAIT;
                end
            end
            S_WDATA: begin
                tx_shift = 1'b1;
                if (tx_last) begin
                    tx_clr   = 1'b1;
                    dwdone_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_RWAIT, S_RDATA: begin
                if (svalid) begin
                    rx_shift = 1'b1;
                    if (rx_last) begin
                        rx_clr    = 1'b1;
                        drdata_d  = {mrdata, rx_data[DATA_WIDTH-1:1]};
                        drvalid_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_RDATA;
                    end
                end else if (to_q == TO_LAST) begin
                    rx_clr  = 1'b1;
                    derr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_DONE: begin
                mode_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                mode_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        mvalid_d = (state_d == S_ADDR) || (state_d == S_WDATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            to_q      <= '0;
            drdata_q  <= '0;
            drvalid_q <= 1'b0;
            dwdone_q  <= 1'b0;
            derr_q    <= 1'b0;
            mvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            to_q      <= to_d;
            drdata_q  <= drdata_d;
            drvalid_q <= drvalid_d;
            dwdone_q  <= dwdone_d;
            derr_q    <= derr_d;
            mvalid_q  <= mvalid_d;
        end
    end

    // Only the outgoing bit of tx and the upper bits of rx feed the datapath.
    assign unused_bits = ^{tx_data[TX_W-1:1], rx_data[0]};

    assign dready    = (state_q == S_IDLE);
    assign drdata    = drdata_q;
    assign drvalid   = drvalid_q;
    assign dwdone    = dwdone_q;
    assign derr      = derr_q;
    assign mwdata    = tx_data[0];
    assign mmode     = mode_q;
    assign mvalid    = mvalid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port with a queue scoreboard and a negedge monitor.
module tb_master_port;
    import bus_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 16;

    localparam logic [1:0] EV_WDONE = 2'd0;
    localparam logic [1:0] EV_RD    = 2'd1;
    localparam logic [1:0] EV_ERR   = 2'd2;

    logic          clk, rst, dvalid, dmode;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic          dready;
    logic [DW-1:0] drdata;
    logic          drvalid, dwdone, derr;
    logic          mwdata, mmode, mvalid, mrdata, svalid;
    state_e        dbg_state;

    logic [1:0]    exp_bit_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [1:0]    exp_evt_q[$];

    int checks   = 0;
    int failures = 0;

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .dvalid    (dvalid),
        .dmode     (dmode),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dready    (dready),
        .drdata    (drdata),
        .drvalid   (drvalid),
        .dwdone    (dwdone),
        .derr      (derr),
        .mwdata    (mwdata),
        .mmode     (mmode),
        .mvalid    (mvalid),
        .mrdata    (mrdata),
        .svalid    (svalid),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=time_expired required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bits(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i < AW) exp_bit_q.push_back({mode, a[i]});
            else        exp_bit_q.push_back({mode, d[i-AW]});
        end
    endtask

    // driver tasks
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!dready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", dready, 1);
    endtask

    task automatic issue(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        dvalid = 1'b1;
        dmode  = mode;
        daddr  = a;
        dwdata = d;
        @(posedge clk);
        #1 dvalid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int nv, at;
        push_bits(1'b1, a, d, AW + DW);
        exp_evt_q.push_back(EV_WDONE);
        issue(1'b1, a, d);
        nv = 0;
        at = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (mvalid) nv++;
            if (dwdone) begin
                at = n;
                break;
            end
        end
        check("wr_mvalid_cycles", nv, AW + DW);
        check("wr_dwdone_cycle", at, AW + DW + 1);
        @(negedge clk);
        check("wr_ready_after", dready, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] rd, input int lead,
                           input int gap_after, input int gap_len);
        push_bits(1'b0, a, '0, AW);
        exp_evt_q.push_back(EV_RD);
        exp_rd_q.push_back(rd);
        issue(1'b0, a, '0);
        repeat (AW + lead - 1) @(posedge clk);
        #1;
        for (int k = 0; k < DW; k++) begin
            svalid = 1'b1;
            mrdata = rd[k];
            @(posedge clk);
            #1;
            svalid = 1'b0;
            mrdata = 1'b0;
            if (k == gap_after) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        check("rd_drvalid", drvalid, 1);
        check("rd_drdata", drdata, rd);
        check("rd_mmode", mmode, 0);
        check("rd_derr", derr, 0);
    endtask

    task automatic do_timeout_read(input logic [AW-1:0] a, input logic [DW-1:0] prev);
        int at;
        push_bits(1'b0, a, '0, AW);
        exp_evt_q.push_back(EV_ERR);
        issue(1'b0, a, '0);
        at = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (derr) begin
                at = n;
                break;
            end
        end
        check("to_derr_cycle", at, AW + TO + 1);
        check("to_drdata_kept", drdata, prev);
        check("to_drvalid", drvalid, 0);
        @(negedge clk);
        check("to_ready", dready, 1);
    endtask

    task automatic do_held();
        push_bits(1'b1, 12'h2B7, 8'h4D, AW + DW);
        exp_evt_q.push_back(EV_WDONE);
        wait_ready();
        dvalid = 1'b1;
        dmode  = 1'b1;
        daddr  = 12'h2B7;
        dwdata = 8'h4D;
        @(posedge clk);
        for (int n = 1; n <= 22; n++) begin
            #1;
            daddr  = 12'h100 + 12'(n);
            dwdata = 8'hC3;
            if (n == 22) begin
                push_bits(1'b1, 12'h116, 8'hC3, AW + DW);
                exp_evt_q.push_back(EV_WDONE);
            end
            @(negedge clk);
            if (n == 21) check("held_busy_in_done", dready, 0);
            if (n == 22) check("held_ready_idle", dready, 1);
            @(posedge clk);
        end
        #1 dvalid = 1'b0;
        @(negedge clk);
        check("held_second_start", mvalid, 1);
        wait_ready();
    endtask

    task automatic do_reset_mid();
        push_bits(1'b1, 12'h6F1, 8'h99, 6);
        issue(1'b1, 12'h6F1, 8'h99);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mvalid", mvalid, 0);
        check("rst_dready", dready, 1);
        check("rst_mmode", mmode, 0);
        check("rst_mwdata", mwdata, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [1:0] e;
        logic [1:0] k;
        if (!rst) begin
            if (mvalid) begin
                if (exp_bit_q.size() == 0) begin
                    check("unexpected_mvalid", mvalid, 0);
                end else begin
                    e = exp_bit_q.pop_front();
                    check("mwdata", mwdata, e[0]);
                    check("mmode", mmode, e[1]);
                end
            end
            if (dwdone || drvalid || derr) begin
                if (exp_evt_q.size() == 0) begin
                    check("unexpected_event", {dwdone, drvalid, derr}, 0);
                end else begin
                    k = exp_evt_q.pop_front();
                    check("ev_dwdone", dwdone, k == EV_WDONE);
                    check("ev_drvalid", drvalid, k == EV_RD);
                    check("ev_derr", derr, k == EV_ERR);
                    if (drvalid && k == EV_RD && exp_rd_q.size() != 0)
                        check("ev_drdata", drdata, exp_rd_q.pop_front());
                end
            end
        end
    end

    // main sequence and report
    initial begin
        rst    = 1'b1;
        dvalid = 1'b0;
        dmode  = 1'b0;
        daddr  = '0;
        dwdata = '0;
        mrdata = 1'b0;
        svalid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_dready", dready, 1);
        check("reset_mvalid", mvalid, 0);
        check("reset_mwdata", mwdata, 0);
        check("reset_mmode", mmode, 0);
        check("reset_drdata", drdata, 0);
        check("reset_drvalid", drvalid, 0);
        check("reset_dwdone", dwdone, 0);
        check("reset_derr", derr, 0);
        check("reset_state", dbg_state, S_IDLE);

        do_write(12'hA5C, 8'h3E);
        do_read(12'h012, 8'h96, 2, -1, 0);
        do_read(12'h7E5, 8'h5A, 1, 3, 3);
        do_timeout_read(12'h333, 8'h5A);
        do_held();
        do_reset_mid();
        do_write(12'h3C7, 8'h81);
        do_read(12'hFFF, 8'h01, 1, -1, 0);

        repeat (3) @(negedge clk);
        check("sb_bits_left", exp_bit_q.size(), 0);
        check("sb_events_left", exp_evt_q.size(), 0);
        check("sb_rdata_left", exp_rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
